// File: rtl/aim_match_drain_pkg.sv
// Shared widths, FSM encoding and output-element layout for the AIM match drain.
package aim_pkg;

    localparam int N_ENTRY = 32;
    localparam int W_W     = 16;
    localparam int IA_CH   = 16;
    localparam int IA_W    = 8;

    localparam int POS_W = 9;
    localparam int CNT_W = $clog2(N_ENTRY + 1);
    localparam int IDX_W = (N_ENTRY > 1) ? $clog2(N_ENTRY) : 1;
    localparam int IAX_W = (IA_CH > 1) ? $clog2(IA_CH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [W_W-1:0]   weight;
        logic [IA_W-1:0]  act;
        logic [POS_W-1:0] pos;
        logic             last;
    } elem_t;

endpackage

// File: rtl/aim_match_drain_prio_enc.sv
// Lowest-set-bit encoder over the pending match mask; also flags a single remaining bit.
module aim_prio_enc
    import aim_pkg::*;
#(
    parameter int N  = N_ENTRY,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_mask,
    output logic [IW-1:0] o_idx,
    output logic          o_found,
    output logic          o_onehot
);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_mask[i]) o_idx = IW'(i);
        end
    end

    assign o_found  = |i_mask;
    assign o_onehot = o_found && ((i_mask & (i_mask - N'(1))) == '0);

endmodule

// File: rtl/aim_match_drain.sv
// Snapshots an AIM result on i_finish and drains matched entries as a valid/ready stream.
// Optional AIM_DRAIN_RANGE_CHECK_EN drops out-of-range positions at capture and adds o_range_err.
module aim_match_drain
    import aim_pkg::*;
(
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_finish,
    input  logic [N_ENTRY-1:0]                i_valid,
    input  logic [N_ENTRY-1:0][POS_W-1:0]     i_pos,
    input  logic [N_ENTRY-1:0][W_W-1:0]       i_word,
    input  logic [IA_CH-1:0][IA_W-1:0]        i_IA,
    input  logic                              i_ready,
    output logic                              o_valid,
    output logic [W_W-1:0]                    o_weight,
    output logic [IA_W-1:0]                   o_act,
    output logic [POS_W-1:0]                  o_pos,
    output logic                              o_last,
    output logic                              o_busy,
    output logic                              o_done,
    output logic                              o_overrun,
    output logic [CNT_W-1:0]                  o_count
`ifdef AIM_DRAIN_RANGE_CHECK_EN
    ,
    output logic                              o_range_err
`endif
);

    state_e                          r_state;
    logic [N_ENTRY-1:0]              r_pend;
    logic [N_ENTRY-1:0][POS_W-1:0]   r_pos_s;
    logic [N_ENTRY-1:0][W_W-1:0]     r_word_s;
    logic [IA_CH-1:0][IA_W-1:0]      r_ia_s;
    elem_t                           r_elem;
    logic                            r_valid;
    logic                            r_busy;
    logic                            r_done;
    logic                            r_overrun;
    logic                            r_primed;
    logic [CNT_W-1:0]                r_count;

    logic [IDX_W-1:0]                w_idx;
    logic                            w_found;
    logic                            w_onehot;
    logic                            w_hs;
    logic                            w_load;
    logic                            w_valid_nxt;
    logic                            w_drained;
    logic [N_ENTRY-1:0]              w_pend_nxt;
    logic [N_ENTRY-1:0]              w_cap_mask;
    elem_t                           w_elem;

    // r_pend holds entries not yet moved into the output stage, so the
    // encoder always points at the next element to present.
    aim_prio_enc #(.N(N_ENTRY), .IW(IDX_W)) u_enc (
        .i_mask   (r_pend),
        .o_idx    (w_idx),
        .o_found  (w_found),
        .o_onehot (w_onehot)
    );

`ifdef AIM_DRAIN_RANGE_CHECK_EN
    logic [N_ENTRY-1:0] w_oob;
    logic               r_range_err;

    always_comb begin
        w_oob = '0;
        for (int i = 0; i < N_ENTRY; i++) begin
            w_oob[i] = (int'(i_pos[i]) >= IA_CH);
        end
    end

    assign w_cap_mask  = i_valid & ~w_oob;
    assign o_range_err = r_range_err;
`else
    assign w_cap_mask  = i_valid;
`endif

    assign w_hs        = r_valid & i_ready;
    assign w_load      = (r_state == ST_EMIT) && w_found && (!r_valid || w_hs);
    assign w_pend_nxt  = w_load ? (r_pend & ~(N_ENTRY'(1) << w_idx)) : r_pend;
    assign w_valid_nxt = w_load || (r_valid && !i_ready);
    // r_primed gives an empty capture one settle cycle in EMIT before DONE.
    assign w_drained   = r_primed && (w_pend_nxt == '0) && !w_valid_nxt;

    always_comb begin
        w_elem.weight = r_word_s[w_idx];
        w_elem.pos    = r_pos_s[w_idx];
        w_elem.act    = r_ia_s[r_pos_s[w_idx][IAX_W-1:0]];
        w_elem.last   = w_onehot;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_pend    <= '0;
            r_pos_s   <= '0;
            r_word_s  <= '0;
            r_ia_s    <= '0;
            r_elem    <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            r_primed  <= 1'b0;
            r_count   <= '0;
`ifdef AIM_DRAIN_RANGE_CHECK_EN
            r_range_err <= 1'b0;
`endif
        end else begin
            r_done    <= 1'b0;
            r_overrun <= i_finish && (r_state != ST_IDLE);
            r_valid   <= w_valid_nxt;
`ifdef AIM_DRAIN_RANGE_CHECK_EN
            r_range_err <= i_finish && (r_state == ST_IDLE) && |(i_valid & w_oob);
`endif
            if (w_load) r_elem <= w_elem;
            if (w_hs)   r_count <= r_count + CNT_W'(1);

            case (r_state)
                ST_IDLE: begin
                    if (i_finish) begin
                        r_pend   <= w_cap_mask;
                        r_pos_s  <= i_pos;
                        r_word_s <= i_word;
                        r_ia_s   <= i_IA;
                        r_count  <= '0;
                        r_busy   <= 1'b1;
                        r_primed <= 1'b0;
                        r_state  <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    r_pend   <= w_pend_nxt;
                    r_primed <= 1'b1;
                    if (w_drained) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_valid   = r_valid;
    assign o_weight  = r_elem.weight;
    assign o_act     = r_elem.act;
    assign o_pos     = r_elem.pos;
    assign o_last    = r_elem.last;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_overrun = r_overrun;
    assign o_count   = r_count;

endmodule

// File: tb/tb_aim_match_drain.sv
// Scoreboard bench for aim_match_drain: captures are modelled as an ordered list of
// matched entries; a monitor pops and compares on every handshake, done and overrun.
module tb_aim_match_drain;
    import aim_pkg::*;

    logic                          i_clk = 1'b0;
    logic                          i_rst_n = 1'b0;
    logic                          i_finish = 1'b0;
    logic [N_ENTRY-1:0]            i_valid = '0;
    logic [N_ENTRY-1:0][POS_W-1:0] i_pos = '0;
    logic [N_ENTRY-1:0][W_W-1:0]   i_word = '0;
    logic [IA_CH-1:0][IA_W-1:0]    i_IA = '0;
    logic                          i_ready = 1'b1;
    logic                          o_valid, o_last, o_busy, o_done, o_overrun;
    logic [W_W-1:0]                o_weight;
    logic [IA_W-1:0]               o_act;
    logic [POS_W-1:0]              o_pos;
    logic [CNT_W-1:0]              o_count;
`ifdef AIM_DRAIN_RANGE_CHECK_EN
    logic                          o_range_err;
`endif

    aim_match_drain dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_finish(i_finish), .i_valid(i_valid),
        .i_pos(i_pos), .i_word(i_word), .i_IA(i_IA), .i_ready(i_ready),
        .o_valid(o_valid), .o_weight(o_weight), .o_act(o_act), .o_pos(o_pos),
        .o_last(o_last), .o_busy(o_busy), .o_done(o_done), .o_overrun(o_overrun),
        .o_count(o_count)
`ifdef AIM_DRAIN_RANGE_CHECK_EN
        , .o_range_err(o_range_err)
`endif
    );

    typedef struct {
        logic [W_W-1:0]   w;
        logic [IA_W-1:0]  a;
        logic [POS_W-1:0] p;
        logic             l;
    } exp_t;
    typedef struct {
        int     n;
        longint c;
    } done_t;

    exp_t   exp_q[$];
    done_t  done_q[$];
    longint ovr_q[$];
    longint rerr_q[$];
    int     n_pass = 0;
    int     n_tot = 0;
    longint cyc = 0;
    bit     rnd_ready = 1'b0;
    longint stall_at = -100;
    int     stall_len = 0;
    bit     prev_stall = 1'b0;
    logic [63:0] prev_payload = '0;

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Ready changes just after the edge so the monitor sees a settled value.
    always begin
        @(posedge i_clk);
        #1;
        if (rnd_ready) i_ready = ($urandom_range(0, 3) != 0);
        else if (cyc >= stall_at && cyc < stall_at + stall_len) i_ready = 1'b0;
        else i_ready = 1'b1;
    end

    always @(negedge i_clk) begin
        logic [63:0] pl;
        exp_t  e;
        done_t d;
        pl = 64'({o_weight, o_act, o_pos, o_last});
        if (i_rst_n) begin
            if (prev_stall) begin
                check("hold_valid", 64'(o_valid), 64'd1);
                check("hold_payload", pl, prev_payload);
            end
            if (o_valid && exp_q.size() == 0) check("spurious_valid", 64'(o_valid), 64'd0);
            else if (o_valid && i_ready) begin
                e = exp_q.pop_front();
                check("weight", 64'(o_weight), 64'(e.w));
                check("act", 64'(o_act), 64'(e.a));
                check("pos", 64'(o_pos), 64'(e.p));
                check("last", 64'(o_last), 64'(e.l));
            end
            prev_stall   = o_valid && !i_ready;
            prev_payload = pl;
            if (o_done) begin
                if (done_q.size() == 0) check("spurious_done", 64'(o_done), 64'd0);
                else begin
                    d = done_q.pop_front();
                    check("done_count", 64'(o_count), 64'(d.n));
                    check("drain_complete", 64'(exp_q.size()), 64'd0);
                    if (d.c >= 0) check("done_cycle", 64'(cyc), 64'(d.c));
                end
            end
            if (o_overrun) begin
                if (ovr_q.size() == 0) check("spurious_overrun", 64'(o_overrun), 64'd0);
                else check("overrun_cycle", 64'(cyc), 64'(ovr_q.pop_front()));
            end
`ifdef AIM_DRAIN_RANGE_CHECK_EN
            if (o_range_err) begin
                if (rerr_q.size() == 0) check("spurious_range_err", 64'(o_range_err), 64'd0);
                else check("range_err_cycle", 64'(cyc), 64'(rerr_q.pop_front()));
            end
`endif
        end else prev_stall = 1'b0;
    end

    task automatic rand_inputs();
        for (int i = 0; i < N_ENTRY; i++) begin
            i_pos[i]  = POS_W'($urandom_range(0, 2 * IA_CH - 1));
            i_word[i] = W_W'($urandom);
        end
        for (int j = 0; j < IA_CH; j++) i_IA[j] = IA_W'($urandom);
    endtask

    task automatic pattern_inputs();
        i_pos = '0;
        for (int j = 0; j < N_ENTRY; j++) i_word[j] = W_W'(j + 4);
        for (int j = 0; j < IA_CH; j++) i_IA[j] = IA_W'(j + 2);
        i_pos[0] = POS_W'(3);
        i_pos[2] = POS_W'(7);
    endtask

    // Expected stream: matched entries in ascending order, act = IA[pos mod IA_CH].
    task automatic issue(input logic [N_ENTRY-1:0] m, input bit timed, input int extra,
                         output longint k);
        logic [N_ENTRY-1:0] em;
        int   n;
        int   last_i;
        bit   rerr;
        exp_t e;
        em = m; n = 0; last_i = -1; rerr = 1'b0;
        @(negedge i_clk);
`ifdef AIM_DRAIN_RANGE_CHECK_EN
        for (int i = 0; i < N_ENTRY; i++)
            if (em[i] && int'(i_pos[i]) >= IA_CH) begin em[i] = 1'b0; rerr = 1'b1; end
`endif
        for (int i = 0; i < N_ENTRY; i++) if (em[i]) last_i = i;
        for (int i = 0; i < N_ENTRY; i++) begin
            if (em[i]) begin
                e.w = i_word[i];
                e.a = i_IA[int'(i_pos[i]) % IA_CH];
                e.p = i_pos[i];
                e.l = (i == last_i);
                exp_q.push_back(e);
                n++;
            end
        end
        i_valid  = m;
        i_finish = 1'b1;
        k = cyc + 1;
        done_q.push_back('{n, timed ? ((n == 0) ? k + 2 : k + 1 + n + extra) : -1});
        if (rerr) rerr_q.push_back(k);
        @(negedge i_clk);
        i_finish = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 400 && !seen; t++) begin
            @(negedge i_clk);
            seen = o_done;
        end
        check(nm, 64'(seen), 64'd1);
        @(negedge i_clk);
    endtask

    task automatic check_zero_outputs(input string nm);
        check({nm, "_valid"}, 64'(o_valid), 64'd0);
        check({nm, "_weight"}, 64'(o_weight), 64'd0);
        check({nm, "_act"}, 64'(o_act), 64'd0);
        check({nm, "_pos"}, 64'(o_pos), 64'd0);
        check({nm, "_last"}, 64'(o_last), 64'd0);
        check({nm, "_busy"}, 64'(o_busy), 64'd0);
        check({nm, "_done"}, 64'(o_done), 64'd0);
        check({nm, "_overrun"}, 64'(o_overrun), 64'd0);
        check({nm, "_count"}, 64'(o_count), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint k;
        repeat (3) @(negedge i_clk);
        check_zero_outputs("reset");
        #2 i_rst_n = 1'b1;

        // Two sparse matches, ready high.
        pattern_inputs();
        issue(N_ENTRY'(32'h5), 1'b1, 0, k);
        check("busy_after_capture", 64'(o_busy), 64'd1);
        wait_done("t1_done_seen");
        check("t1_count_held", 64'(o_count), 64'd2);
        check("t1_busy_low", 64'(o_busy), 64'd0);

        // Same, ready low three cycles after the first handshake.
        pattern_inputs();
        issue(N_ENTRY'(32'h5), 1'b1, 3, k);
        stall_at = k + 2;
        stall_len = 3;
        wait_done("t2_done_seen");
        stall_len = 0;

        // Empty mask.
        rand_inputs();
        issue('0, 1'b1, 0, k);
        wait_done("t3_done_seen");
        check("t3_count", 64'(o_count), 64'd0);

        // Every entry matched.
        rand_inputs();
        issue('1, 1'b1, 0, k);
        wait_done("t4_done_seen");

        // Second finish mid-drain is ignored.
        rand_inputs();
        issue('1, 1'b1, 0, k);
        while (cyc < k + 4) @(negedge i_clk);
        rand_inputs();
        i_valid  = N_ENTRY'($urandom);
        i_finish = 1'b1;
        ovr_q.push_back(k + 5);
        @(negedge i_clk);
        i_finish = 1'b0;
        wait_done("t5_done_seen");

        // Reset after two handshakes, then a fresh drain.
        rand_inputs();
        issue('1, 1'b1, 0, k);
        while (cyc < k + 3) @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1 check_zero_outputs("midreset");
        exp_q.delete();
        done_q.delete();
        ovr_q.delete();
        rerr_q.delete();
        @(negedge i_clk);
        #2 i_rst_n = 1'b1;
        pattern_inputs();
        issue(N_ENTRY'(32'h5), 1'b1, 0, k);
        wait_done("t6_done_seen");

`ifdef AIM_DRAIN_RANGE_CHECK_EN
        pattern_inputs();
        i_pos[1] = POS_W'(IA_CH);
        issue(N_ENTRY'(32'h7), 1'b1, 0, k);
        wait_done("t7_done_seen");
`endif

        // Random masks and random backpressure.
        rnd_ready = 1'b1;
        for (int it = 0; it < 25; it++) begin
            logic [N_ENTRY-1:0] m;
            rand_inputs();
            case ($urandom_range(0, 3))
                0: m = '0;
                1: m = N_ENTRY'($urandom) & N_ENTRY'($urandom) & N_ENTRY'($urandom);
                2: m = N_ENTRY'($urandom);
                default: m = N_ENTRY'($urandom) | N_ENTRY'($urandom);
            endcase
            issue(m, 1'b0, 0, k);
            wait_done("rand_done_seen");
        end
        rnd_ready = 1'b0;
        repeat (3) @(negedge i_clk);

        check("final_exp_q_empty", 64'(exp_q.size()), 64'd0);
        check("final_done_q_empty", 64'(done_q.size()), 64'd0);
        check("final_ovr_q_empty", 64'(ovr_q.size()), 64'd0);
        check("final_rerr_q_empty", 64'(rerr_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
